// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned per operation.
// One Booth step per cycle over WIDTH+1 extended bits, then one cycle to publish the product.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] valueA,
  input  logic [WIDTH-1:0] valueB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mostSig,
  output logic [WIDTH-1:0] leastSig
);
  localparam int PW = 2*WIDTH + 3;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state;
  logic [WIDTH:0] m;
  logic [PW-1:0]  p;
  logic [CW-1:0]  cnt;

  logic [WIDTH:0] upper;
  logic [PW-1:0]  p_add;
  logic [PW-1:0]  p_step;

  // Upper field wraps modulo 2^(WIDTH+1); the shift replicates the MSB.
  always_comb begin
    upper = p[PW-1 -: WIDTH+1];
    case (p[1:0])
      2'b01:   upper = upper + m;
      2'b10:   upper = upper - m;
      default: upper = p[PW-1 -: WIDTH+1];
    endcase
    p_add  = {upper, p[WIDTH+1:0]};
    p_step = {p_add[PW-1], p_add[PW-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      m        <= '0;
      p        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mostSig  <= '0;
      leastSig <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= {is_signed & valueA[WIDTH-1], valueA};
            p     <= {{(WIDTH+1){1'b0}}, is_signed & valueB[WIDTH-1], valueB, 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          p   <= p_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        FIN: begin
          mostSig  <= p[2*WIDTH:WIDTH+1];
          leastSig <= p[WIDTH:1];
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench: WIDTH=32 and WIDTH=8 instances, expected products queued at issue,
// popped and compared (value and latency) whenever done pulses.
module tb_booth_mult_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start32 = 0, sgn32 = 0;
  logic [31:0] a32 = 0, b32 = 0, ms32, ls32;
  logic        busy32, done32;
  logic        start8 = 0, sgn8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, ms8, ls8;
  logic        busy8, done8;

  booth_mult_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .is_signed(sgn32),
    .valueA(a32), .valueB(b32), .busy(busy32), .done(done32),
    .mostSig(ms32), .leastSig(ls32));

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .is_signed(sgn8),
    .valueA(a8), .valueB(b8), .busy(busy8), .done(done8),
    .mostSig(ms8), .leastSig(ls8));

  typedef struct {
    logic [63:0] prod;
    int          t;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clock) cyc++;

  function automatic logic [63:0] model32(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = {{32{s & a[31]}}, a};
    y = {{32{s & b[31]}}, b};
    return x * y;
  endfunction

  function automatic logic [15:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] x, y;
    x = {{8{s & a[7]}}, a};
    y = {{8{s & b[7]}}, b};
    return x * y;
  endfunction

  // Monitors: pop on every done pulse; latency from start edge must be WIDTH+2.
  always @(negedge clock) begin
    if (done32) begin
      exp_t e;
      compared++;
      if (q32.size() == 0) begin
        mismatched++;
        $display("FAIL done32_unexpected: got %h_%h, no result was required", ms32, ls32);
      end else begin
        e = q32.pop_front();
        if ({ms32, ls32} !== e.prod || (cyc - e.t) != 34) begin
          mismatched++;
          $display("FAIL result32: got %h_%h lat %0d, required %h lat 34",
                   ms32, ls32, cyc - e.t, e.prod);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (done8) begin
      exp_t e;
      compared++;
      if (q8.size() == 0) begin
        mismatched++;
        $display("FAIL done8_unexpected: got %h%h, no result was required", ms8, ls8);
      end else begin
        e = q8.pop_front();
        if ({ms8, ls8} !== e.prod[15:0] || (cyc - e.t) != 10) begin
          mismatched++;
          $display("FAIL result8: got %h%h lat %0d, required %h lat 10",
                   ms8, ls8, cyc - e.t, e.prod[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] req);
    exp_t e;
    start32 = 1; sgn32 = s; a32 = a; b32 = b;
    @(posedge clock); #1;
    start32 = 0;
    e.prod = req; e.t = cyc;
    q32.push_back(e);
  endtask

  task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] req);
    exp_t e;
    start8 = 1; sgn8 = s; a8 = a; b8 = b;
    @(posedge clock); #1;
    start8 = 0;
    e.prod = {48'b0, req}; e.t = cyc;
    q8.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: %0d/%0d results outstanding, required 0", name, q32.size(), q8.size());
      q32.delete(); q8.delete();
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic        bad;
    logic        s;
    logic [31:0] ra, rb;
    logic [7:0]  r8a, r8b;

    repeat (2) @(posedge clock);
    #1;
    check("reset_busy_done32", {62'b0, busy32, done32}, 64'd0);
    check("reset_out32", {ms32, ls32}, 64'd0);
    check("reset_out8", {48'b0, busy8, done8, 6'b0, ms8, ls8}, 64'd0);
    reset = 0;
    @(posedge clock); #1;

    // Directed, WIDTH=32
    issue32(1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1); drain("neg3x5");
    issue32(1, 32'h80000000, 32'h80000000, 64'h40000000_00000000); drain("min_sq_s");
    issue32(0, 32'h80000000, 32'h80000000, 64'h40000000_00000000); drain("min_sq_u");
    issue32(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001); drain("max_sq_u");
    issue32(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001); drain("m1_sq_s");

    // Directed, WIDTH=8
    issue8(1, 8'h80, 8'h7F, 16'hC080); drain("w8_s");
    issue8(0, 8'h80, 8'h7F, 16'h3F80); drain("w8_u");
    issue8(0, 8'hFF, 8'hFF, 16'hFE01); drain("w8_ff_u");
    issue8(1, 8'hFF, 8'hFF, 16'h0001); drain("w8_ff_s");

    // Start while busy: the re-pulse is ignored and busy stays high through FIN
    issue32(0, 32'd7, 32'd6, 64'd42);
    bad = 0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clock);
      if (!busy32) bad = 1;
      if (i == 8) begin start32 = 1; a32 = 2; b32 = 2; end
      if (i == 9) start32 = 0;
    end
    check("busy_held", {63'b0, bad}, 64'd0);
    drain("start_while_busy");

    // Held start relaunches every WIDTH+3 cycles with the current operands
    begin
      exp_t e;
      start8 = 1; sgn8 = 1; a8 = 8'hFD; b8 = 8'h05;
      @(posedge clock); #1;
      e.prod = 64'h000000000000FFF1; e.t = cyc;
      q8.push_back(e);
      e.t = cyc + 11;
      q8.push_back(e);
      repeat (11) @(posedge clock);
      #1 start8 = 0;
      drain("held_start");
    end

    // Reset mid-operation aborts; new operation takes full latency
    issue32(1, 32'h12345678, 32'h9ABCDEF0, 64'd0);
    repeat (15) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    q32.delete();
    @(negedge clock);
    check("abort_busy_done", {62'b0, busy32, done32}, 64'd0);
    check("abort_out", {ms32, ls32}, 64'd0);
    @(posedge clock); #1;
    issue32(0, 32'd3, 32'd4, 64'd12); drain("after_abort");

    // Reset beats start in the same cycle
    start32 = 1; reset = 1; a32 = 9; b32 = 9;
    @(posedge clock); #1;
    start32 = 0; reset = 0;
    @(negedge clock);
    check("reset_over_start", {63'b0, busy32}, 64'd0);
    @(posedge clock); #1;

    // Random operands checked against the behavioural product
    for (int i = 0; i < 40; i++) begin
      s = i[0];
      ra = $urandom; rb = $urandom;
      r8a = 8'($urandom); r8b = 8'($urandom);
      if (i == 2) r8a = 8'h00;
      fork
        issue32(s, ra, rb, model32(s, ra, rb));
        issue8(s, r8a, r8b, model8(s, r8a, r8b));
      join
      drain("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier with a start/done handshake and a per-operation signed/unsigned mode. It is the next generation of the datapath's 32-bit multiplier and serves the MULT/MULTU path of the processor's multi-cycle control unit. The control unit pulses `start`, stalls while `busy` is high, and writes `mostSig`/`leastSig` into HI/LO on `done`.

## Interface
- `WIDTH`, default 32: operand width in bits; legal values are 4 to 64.
- `clock`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE.
- `is_signed`  in  1: 1 selects two's-complement operands (MULT); 0 selects unsigned (MULTU). Captured with `start`.
- `valueA`  in  WIDTH: multiplicand. Captured with `start`.
- `valueB`  in  WIDTH: multiplier. Captured with `start`.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: single-cycle pulse; result is valid from this cycle.
- `mostSig`  out  WIDTH: upper half of the 2·WIDTH-bit product.
- `leastSig`  out  WIDTH: lower half of the 2·WIDTH-bit product.

## Operation
- States:
  - IDLE.
  - RUN: iteration counter 0..WIDTH.
  - FIN: one cycle, drives `done`.
- IDLE with `start`=1:
  - Latch M = `valueA` extended to WIDTH+1 bits: sign-extended if `is_signed`, else zero-extended.
  - Load accumulator P (2·WIDTH+3 bits) = {(WIDTH+1)'b0, extended `valueB`, 1'b0}.
  - Clear the counter and go to RUN.
- RUN, each cycle, using the pair (P[1], P[0]):
  - 01: add M to P's upper WIDTH+1 bits.
  - 10: subtract M from P's upper WIDTH+1 bits (add ~M+1).
  - 00 or 11: no change.
  - Then arithmetic-shift P right by 1, replicating the MSB.
  - All arithmetic is modulo 2^(WIDTH+1) in the upper field.
- RUN lasts exactly WIDTH+1 iterations; the uniform count covers both modes. After the last iteration go to FIN.
- FIN:
  - Register product = P[2·WIDTH:1], truncated to the low 2·WIDTH bits.
  - `mostSig` = product[2·WIDTH-1:WIDTH]; `leastSig` = product[WIDTH-1:0].
  - Next state is IDLE.
- Outputs hold the last result until the next FIN or `reset`. The accumulator is never visible on the outputs mid-operation.
- `start` while in RUN or FIN is ignored; there is no queueing.
- Operand and mode changes after capture have no effect.
- `reset` (any state, including mid-RUN): aborts the operation, state IDLE, counter 0, `busy`=0, `done`=0, `mostSig`=0, `leastSig`=0. Reset has priority over `start` in the same cycle.

## Timing
- `start` sampled at edge k puts the block in RUN, with `busy`=1 visible after edge k.
- Iterations complete at edges k+1 … k+WIDTH+1.
- After edge k+WIDTH+2:
  - `done`=1 and `busy`=0.
  - Result is valid.
  - Latency is WIDTH+2 cycles from start edge to `done`.
- `done` is high for exactly one cycle; FIN itself counts as `busy`=1.
- A `start` held high during the cycle `done` is high is sampled in IDLE at the next edge. Back-to-back issue interval is WIDTH+3 cycles.
- `start` is level-sampled. A `start` held high continuously re-launches on each return to IDLE.

## Test plan
- Signed mode:
  - WIDTH=32, `is_signed`=1, A=0xFFFFFFFD (−3), B=5 → after 34 cycles `done` pulses once; `mostSig`=0xFFFFFFFF, `leastSig`=0xFFFFFFF1.
  - WIDTH=32 signed, A=B=0x80000000 → `mostSig`=0x40000000, `leastSig`=0x00000000.
  - Same operands unsigned → `mostSig`=0x40000000, `leastSig`=0.
- Unsigned mode: WIDTH=32, `is_signed`=0, A=B=0xFFFFFFFF → `mostSig`=0xFFFFFFFE, `leastSig`=0x00000001. Same operands signed → `mostSig`=0, `leastSig`=1.
- Start while busy: `start` with A=7, B=6. Re-pulse `start` with A=2, B=2 at cycle 10 → ignored; result is 42 at cycle 34; `busy` is never dropped early.
- Reset mid-operation: assert `reset` at iteration 15 → next cycle `busy`=0, `done`=0, outputs 0. A new `start` with A=3, B=4 then yields 12 with full latency.
- Parametrisation:
  - WIDTH=8, signed, A=0x80, B=0x7F → {`mostSig`,`leastSig`}=0xC080 after 10 cycles.
  - WIDTH=8, unsigned → 0x3F80.
  - Randomised 1000-vector comparison against a behavioural product for WIDTH ∈ {8,16,32} in both modes.
